// File: rtl/fft_twiddle_stream.sv
// Streaming twiddle-factor source for a radix-2 DIT FFT: one stage request yields
// W = exp(-j*2*pi*k/N) for all N/2 butterflies, LANES per beat, with valid/ready flow control.
module fft_twiddle_stream #(
    parameter int FFT_LOG2N = 6,
    parameter int LANES     = 8,
    parameter int WN_WID    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [2:0]                stage_i,
    input  logic                      inv_i,
    output logic                      start_rdy_o,
    output logic [LANES*WN_WID-1:0]   wn_re_o,
    output logic [LANES*WN_WID-1:0]   wn_im_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic                      err_o
);

    localparam int N     = 1 << FFT_LOG2N;
    localparam int BEATS = N / (2 * LANES);
    localparam int Q     = N / 4;
    localparam int SC    = 64 / N;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = LANES * WN_WID;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [BW-1:0]       beat_p1;
    logic [2:0]          stage_q;
    logic                inv_q;
    logic                vld_p1;
    logic                last_p1;
    logic                err_p1;
    logic [PW-1:0]       re_p1;
    logic [PW-1:0]       im_p1;

    logic                legal;
    logic                accept;
    logic                advance;
    logic                hs_last;
    logic [BW-1:0]       beat_p0;
    logic [2:0]          s_p0;
    logic                inv_p0;
    logic [PW-1:0]       re_p0;
    logic [PW-1:0]       im_p0;
    logic [2*WN_WID-1:0] tw;

    // Quarter-wave cosine in Q8: round(256*cos(2*pi*m/64)), m = 0..16
    function automatic logic [8:0] cos_rom(input logic [4:0] m);
        case (m)
            5'd0:    cos_rom = 9'd256;
            5'd1:    cos_rom = 9'd255;
            5'd2:    cos_rom = 9'd251;
            5'd3:    cos_rom = 9'd245;
            5'd4:    cos_rom = 9'd237;
            5'd5:    cos_rom = 9'd226;
            5'd6:    cos_rom = 9'd213;
            5'd7:    cos_rom = 9'd198;
            5'd8:    cos_rom = 9'd181;
            5'd9:    cos_rom = 9'd162;
            5'd10:   cos_rom = 9'd142;
            5'd11:   cos_rom = 9'd121;
            5'd12:   cos_rom = 9'd98;
            5'd13:   cos_rom = 9'd74;
            5'd14:   cos_rom = 9'd50;
            5'd15:   cos_rom = 9'd25;
            default: cos_rom = 9'd0;
        endcase
    endfunction

    function automatic logic signed [WN_WID-1:0] sext_neg(input logic [8:0] mag, input logic neg);
        logic signed [WN_WID-1:0] v;
        v = signed'({{(WN_WID-9){1'b0}}, mag});
        return neg ? -v : v;
    endfunction

    // Butterfly j of stage s -> exponent k, then fold the half circle onto the quarter-wave ROM
    function automatic logic [2*WN_WID-1:0] twiddle(input int j, input int s, input logic inv);
        int k;
        int kp;
        logic signed [WN_WID-1:0] re;
        logic signed [WN_WID-1:0] im;
        k = (j & ((1 << s) - 1)) << (FFT_LOG2N - 1 - s);
        kp = k - Q;
        if (k < Q) begin
            re = sext_neg(cos_rom(5'(k * SC)), 1'b0);
            im = sext_neg(cos_rom(5'((Q - k) * SC)), 1'b1);
        end else begin
            re = sext_neg(cos_rom(5'((Q - kp) * SC)), 1'b1);
            im = sext_neg(cos_rom(5'(kp * SC)), 1'b1);
        end
        if (inv) begin
            im = -im;
        end
        return {re, im};
    endfunction

    assign legal       = int'(stage_i) < FFT_LOG2N;
    assign hs_last     = vld_p1 && ready_i && last_p1;
    assign start_rdy_o = (state == IDLE) || hs_last;
    assign accept      = start_i && start_rdy_o && legal;
    assign advance     = vld_p1 && ready_i && !last_p1;

    // Stage p0: next beat to present, either beat 0 of a new request or the successor
    always_comb begin
        beat_p0 = accept ? '0 : beat_p1 + BW'(1);
        s_p0    = accept ? stage_i : stage_q;
        inv_p0  = accept ? inv_i : inv_q;
        re_p0   = '0;
        im_p0   = '0;
        tw      = '0;
        for (int l = 0; l < LANES; l++) begin
            tw = twiddle(int'(beat_p0) * LANES + l, int'(s_p0), inv_p0);
            re_p0[l*WN_WID +: WN_WID] = tw[2*WN_WID-1:WN_WID];
            im_p0[l*WN_WID +: WN_WID] = tw[WN_WID-1:0];
        end
    end

    // Stage p1: registered beat; held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            beat_p1 <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            err_p1  <= 1'b0;
            re_p1   <= '0;
            im_p1   <= '0;
        end else begin
            err_p1 <= start_i && start_rdy_o && !legal;
            if (accept || advance) begin
                state   <= RUN;
                beat_p1 <= beat_p0;
                stage_q <= s_p0;
                inv_q   <= inv_p0;
                vld_p1  <= 1'b1;
                last_p1 <= (beat_p0 == BW'(BEATS - 1));
                re_p1   <= re_p0;
                im_p1   <= im_p0;
            end else if (hs_last) begin
                state   <= IDLE;
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign wn_re_o = re_p1;
    assign wn_im_o = im_p1;
    assign valid_o = vld_p1;
    assign last_o  = last_p1;
    assign err_o   = err_p1;

endmodule

// File: tb/tb_fft_twiddle_stream.sv
// Scoreboard bench for fft_twiddle_stream: stimulus pushes expected beats, a monitor pops on handshakes.
module tb_fft_twiddle_stream;

    localparam int LOG2N = 6;
    localparam int LANES = 8;
    localparam int WN    = 10;
    localparam int N     = 1 << LOG2N;
    localparam int BEATS = N / (2 * LANES);
    localparam int PW    = LANES * WN;
    localparam real PI   = 3.14159265358979;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [2:0]    stage_i;
    logic          inv_i;
    logic          start_rdy_o;
    logic [PW-1:0] wn_re_o;
    logic [PW-1:0] wn_im_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
    logic          err_o;

    typedef struct {
        logic [PW-1:0] re;
        logic [PW-1:0] im;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   hs_count   = 0;

    int re_s0[LANES] = '{256, 256, 256, 256, 256, 256, 256, 256};
    int im_s0[LANES] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int re_s1[LANES] = '{256, 0, 256, 0, 256, 0, 256, 0};
    int im_s1[LANES] = '{0, -256, 0, -256, 0, -256, 0, -256};
    int re_s3[LANES] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int im_s3[LANES] = '{0, -98, -181, -237, -256, -237, -181, -98};

    fft_twiddle_stream #(.FFT_LOG2N(LOG2N), .LANES(LANES), .WN_WID(WN)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stage_i(stage_i), .inv_i(inv_i),
        .start_rdy_o(start_rdy_o), .wn_re_o(wn_re_o), .wn_im_o(wn_im_o),
        .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Expected beats from the hand-written per-lane pattern (same for every beat)
    task automatic push_pattern(input int re8[LANES], input int im8[LANES], input logic inv);
        exp_t e;
        int   vi;
        for (int b = 0; b < BEATS; b++) begin
            e.re = '0;
            e.im = '0;
            for (int l = 0; l < LANES; l++) begin
                vi = inv ? -im8[l] : im8[l];
                e.re[l*WN +: WN] = re8[l][WN-1:0];
                e.im[l*WN +: WN] = vi[WN-1:0];
            end
            e.last = (b == BEATS - 1);
            q.push_back(e);
        end
    endtask

    // Expected beats from real-valued cos/sin of the twiddle angle
    task automatic push_model(input int s, input logic inv);
        exp_t e;
        int   j, k, vr, vi;
        real  a;
        for (int b = 0; b < BEATS; b++) begin
            e.re = '0;
            e.im = '0;
            for (int l = 0; l < LANES; l++) begin
                j  = b * LANES + l;
                k  = (j % (1 << s)) * (N >> (s + 1));
                a  = 2.0 * PI * real'(k) / real'(N);
                vr = rnd(256.0 * $cos(a));
                vi = -rnd(256.0 * $sin(a));
                if (inv) vi = -vi;
                e.re[l*WN +: WN] = vr[WN-1:0];
                e.im[l*WN +: WN] = vi[WN-1:0];
            end
            e.last = (b == BEATS - 1);
            q.push_back(e);
        end
    endtask

    task automatic issue(input int s, input logic inv);
        int t;
        @(posedge clk); #1;
        start_i = 1'b1;
        stage_i = 3'(s);
        inv_i   = inv;
        #1;
        t = 0;
        while (!start_rdy_o && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL issue_timeout: start_rdy_o stayed %b, required 1", start_rdy_o);
            start_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        if (s < LOG2N) begin
            check("accept_latency_valid", PW'(valid_o), PW'(1));
        end else begin
            check("illegal_err_pulse", PW'(err_o), PW'(1));
            check("illegal_no_valid", PW'(valid_o), PW'(0));
            @(posedge clk); #1;
            check("illegal_err_one_cycle", PW'(err_o), PW'(0));
            check("illegal_still_no_valid", PW'(valid_o), PW'(0));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || valid_o) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue_empty", PW'(q.size()), PW'(0));
    endtask

    // Monitor: compare each accepted beat, and verify outputs are frozen during stalls
    logic          prev_stall = 1'b0;
    logic [PW-1:0] sv_re, sv_im;
    logic          sv_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", PW'(valid_o), PW'(1));
                check("stall_re_held", wn_re_o, sv_re);
                check("stall_im_held", wn_im_o, sv_im);
                check("stall_last_held", PW'(last_o), PW'(sv_last));
            end
            if (valid_o && ready_i) begin
                hs_count++;
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_beat: got re %h, required no beat", wn_re_o);
                end else begin
                    e = q.pop_front();
                    check("beat_re", wn_re_o, e.re);
                    check("beat_im", wn_im_o, e.im);
                    check("beat_last", PW'(last_o), PW'(e.last));
                end
            end
            prev_stall = valid_o && !ready_i;
            sv_re      = wn_re_o;
            sv_im      = wn_im_o;
            sv_last    = last_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int       hs0;
        logic [3:0] pat;
        pat     = 4'b1001;
        rst     = 1'b1;
        start_i = 1'b0;
        stage_i = '0;
        inv_i   = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", PW'(valid_o), PW'(0));
        check("reset_last", PW'(last_o), PW'(0));
        check("reset_err", PW'(err_o), PW'(0));
        check("reset_re", wn_re_o, PW'(0));
        check("reset_im", wn_im_o, PW'(0));
        check("reset_start_rdy", PW'(start_rdy_o), PW'(1));
        rst = 1'b0;

        push_pattern(re_s0, im_s0, 1'b0); issue(0, 1'b0); drain();
        push_pattern(re_s1, im_s1, 1'b0); issue(1, 1'b0); drain();
        push_pattern(re_s3, im_s3, 1'b0); issue(3, 1'b0); drain();
        push_model(5, 1'b0); issue(5, 1'b0); drain();
        push_model(5, 1'b1); issue(5, 1'b1); drain();

        // Stalled stage 3, then back-to-back request on its final handshake
        hs0 = hs_count;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    ready_i = pat[c % 4];
                end
                ready_i = 1'b1;
            end
            begin
                push_pattern(re_s3, im_s3, 1'b0);
                issue(3, 1'b0);
                push_pattern(re_s1, im_s1, 1'b1);
                issue(1, 1'b1);
                check("stall_handshake_count", PW'(hs_count - hs0), PW'(4));
            end
        join
        drain();

        // Request while busy must be ignored
        ready_i = 1'b0;
        push_model(5, 1'b0);
        issue(5, 1'b0);
        start_i = 1'b1;
        stage_i = 3'd0;
        #1;
        check("busy_start_rdy", PW'(start_rdy_o), PW'(0));
        repeat (2) begin
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        drain();

        issue(6, 1'b0);
        issue(7, 1'b1);

        // Asynchronous reset while beat 2 is presented
        push_pattern(re_s3, im_s3, 1'b0);
        issue(3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", PW'(valid_o), PW'(0));
        check("midrst_last", PW'(last_o), PW'(0));
        check("midrst_re", wn_re_o, PW'(0));
        check("midrst_start_rdy", PW'(start_rdy_o), PW'(1));
        q.delete();
        @(posedge clk); #1;
        rst     = 1'b0;
        ready_i = 1'b1;

        push_pattern(re_s3, im_s3, 1'b1); issue(3, 1'b1); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
